seq_multiplier: RTL and testbench

//   Iterative shift-add multiplier for the ALU: WIDTH x WIDTH -> 2*WIDTH product.

---
 rtl/seq_multiplier_pkg.sv | 34 +++
 rtl/seq_multiplier_if.sv | 41 ++++
 rtl/seq_multiplier_step.sv | 28 ++
 rtl/seq_multiplier.sv | 142 ++++++++++++++
 tb/tb_seq_multiplier.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_multiplier_pkg.sv
// mult_pkg: shared FSM type and helpers for the
// iterative shift-add multiplier (seq_multiplier).
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mult_state_t;

  // Widest operand the abs helper can carry.
  localparam int MAX_W = 128;

  // Counter width for n iterations, never below 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Conditional negate of a w-bit value held
  // zero-extended in MAX_W bits. The low w bits of
  // the result are the magnitude; -2^(w-1) maps to
  // 2^(w-1), still exact as a w-bit unsigned value.
  function automatic logic [MAX_W-1:0] abs_w(
    input logic [MAX_W-1:0] v,
    input int               w,
    input logic             sgn
  );
    if (sgn && v[w-1]) begin
      return -v;
    end
    return v;
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: operand/result handshake bundle.
// master = producer/consumer stage, slave = multiplier.
interface seq_multiplier_if #(
  parameter int WIDTH = 64
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               is_signed;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] prod;

  modport master (
    output in_valid,
    output mcand,
    output mplier,
    output is_signed,
    output flush,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  prod
  );

  modport slave (
    input  in_valid,
    input  mcand,
    input  mplier,
    input  is_signed,
    input  flush,
    input  out_ready,
    output in_ready,
    output out_valid,
    output prod
  );

endinterface

// File: rtl/seq_multiplier_step.sv
// mult_step: K shift-add iterations, LSB first.
// Ports: i_acc (2W), i_mcand (W magnitude) -> o_acc (2W).
module mult_step #(
  parameter int WIDTH = 64,
  parameter int K     = 1
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_mcand,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [2*WIDTH-1:0] w_acc;
  logic [WIDTH:0]     w_sum;

  // Upper half gathers the partial product; the
  // carry of each add re-enters at the MSB on shift.
  always_comb begin
    w_acc = i_acc;
    w_sum = '0;
    for (int i = 0; i < K; i++) begin
      w_sum = {1'b0, w_acc[2*WIDTH-1:WIDTH]}
            + (w_acc[0] ? {1'b0, i_mcand} : '0);
      w_acc = {w_sum, w_acc[WIDTH-1:1]};
    end
    o_acc = w_acc;
  end

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative WIDTH x WIDTH -> 2*WIDTH
// multiplier, BITS_PER_CYCLE multiplier bits per clock.
// Ports: clk, rst_n (async, active low),
//   bus (slave): in_valid/in_ready, mcand, mplier,
//   is_signed, flush, out_valid/out_ready, prod.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH          = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_multiplier_if.slave     bus
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(N - 1);

  mult_state_t        r_state;
  mult_state_t        w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [2*WIDTH-1:0] w_step;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   w_mcand_nxt;
  logic               r_neg;
  logic               w_neg_nxt;
  logic [2*WIDTH-1:0] r_prod;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic               r_out_valid;
  logic               w_out_valid_nxt;

  logic [MAX_W-1:0]   w_mc_full;
  logic [MAX_W-1:0]   w_mp_full;
  logic [WIDTH-1:0]   w_mc_abs;
  logic [WIDTH-1:0]   w_mp_abs;
  logic               w_neg_in;
  logic               w_in_ready;
  logic               w_unused_hi;

  assign w_mc_full = abs_w(MAX_W'(bus.mcand),
                           WIDTH, bus.is_signed);
  assign w_mp_full = abs_w(MAX_W'(bus.mplier),
                           WIDTH, bus.is_signed);
  assign w_mc_abs  = w_mc_full[WIDTH-1:0];
  assign w_mp_abs  = w_mp_full[WIDTH-1:0];
  assign w_unused_hi = ^{w_mc_full[MAX_W-1:WIDTH],
                         w_mp_full[MAX_W-1:WIDTH]};

  assign w_neg_in = bus.is_signed
                  & (bus.mcand[WIDTH-1]
                   ^ bus.mplier[WIDTH-1]);

  // Low while reset is held, otherwise only in IDLE.
  assign w_in_ready    = rst_n & (r_state == IDLE);
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.prod      = r_prod;

  mult_step #(
    .WIDTH (WIDTH),
    .K     (BITS_PER_CYCLE)
  ) u_step (
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .o_acc   (w_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_neg       <= 1'b0;
      r_prod      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_acc       <= w_acc_nxt;
      r_mcand     <= w_mcand_nxt;
      r_neg       <= w_neg_nxt;
      r_prod      <= w_prod_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_acc_nxt       = r_acc;
    w_mcand_nxt     = r_mcand;
    w_neg_nxt       = r_neg;
    w_prod_nxt      = r_prod;
    w_out_valid_nxt = r_out_valid;
    if (bus.flush) begin
      // Abort wins over accept and handoff.
      w_state_nxt     = IDLE;
      w_cnt_nxt       = '0;
      w_out_valid_nxt = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid && w_in_ready) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
            w_acc_nxt   = {{WIDTH{1'b0}}, w_mp_abs};
            w_mcand_nxt = w_mc_abs;
            w_neg_nxt   = w_neg_in;
          end
        end
        RUN: begin
          w_acc_nxt = w_step;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            w_prod_nxt      = r_neg ? -w_step
                                    : w_step;
            w_out_valid_nxt = 1'b1;
            w_cnt_nxt       = '0;
            w_state_nxt     = DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            w_out_valid_nxt = 1'b0;
            w_state_nxt     = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: three multipliers (K=1,4,8)
// checked every cycle against a behavioural model.
module tb_seq_multiplier;

  logic clk;
  logic [127:0] pr [3];
  logic ir [3];
  logic ov [3];
  logic iv [3];
  logic sg [3];
  logic fl [3];
  logic ordy [3];
  logic rstn [3];
  logic [63:0] mc [3];
  logic [63:0] mp [3];

  int nvec = 0;
  int nerr = 0;

  // Model state: 0 idle, 1 busy, 2 result held.
  int m_st [3] = '{default: 0};
  int m_left [3] = '{default: 0};
  int m_done [3] = '{default: 0};
  logic [127:0] m_exp [3];
  logic [127:0] m_prod [3];
  int nn [3] = '{64, 16, 8};

  seq_multiplier_if #(.WIDTH(64)) b0 ();
  seq_multiplier_if #(.WIDTH(64)) b1 ();
  seq_multiplier_if #(.WIDTH(64)) b2 ();

  seq_multiplier #(.WIDTH(64), .BITS_PER_CYCLE(1))
    u_k1 (.clk(clk), .rst_n(rstn[0]), .bus(b0));
  seq_multiplier #(.WIDTH(64), .BITS_PER_CYCLE(4))
    u_k4 (.clk(clk), .rst_n(rstn[1]), .bus(b1));
  seq_multiplier #(.WIDTH(64), .BITS_PER_CYCLE(8))
    u_k8 (.clk(clk), .rst_n(rstn[2]), .bus(b2));

  assign b0.in_valid  = iv[0];
  assign b0.mcand     = mc[0];
  assign b0.mplier    = mp[0];
  assign b0.is_signed = sg[0];
  assign b0.flush     = fl[0];
  assign b0.out_ready = ordy[0];
  assign ir[0] = b0.in_ready;
  assign ov[0] = b0.out_valid;
  assign pr[0] = b0.prod;

  assign b1.in_valid  = iv[1];
  assign b1.mcand     = mc[1];
  assign b1.mplier    = mp[1];
  assign b1.is_signed = sg[1];
  assign b1.flush     = fl[1];
  assign b1.out_ready = ordy[1];
  assign ir[1] = b1.in_ready;
  assign ov[1] = b1.out_valid;
  assign pr[1] = b1.prod;

  assign b2.in_valid  = iv[2];
  assign b2.mcand     = mc[2];
  assign b2.mplier    = mp[2];
  assign b2.is_signed = sg[2];
  assign b2.flush     = fl[2];
  assign b2.out_ready = ordy[2];
  assign ir[2] = b2.in_ready;
  assign ov[2] = b2.out_valid;
  assign pr[2] = b2.prod;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [127:0] ref_prod(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic        s
  );
    logic signed [127:0] sa;
    logic signed [127:0] sb;
    if (s) begin
      sa = $signed({{64{a[63]}}, a});
      sb = $signed({{64{b[63]}}, b});
      return sa * sb;
    end
    return {64'd0, a} * {64'd0, b};
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(5))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      4: return 64'($urandom_range(15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic chk(
    input string        nm,
    input logic [127:0] act,
    input logic [127:0] req
  );
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s got %h req %h", nm, act, req);
    end
  endtask

  // Compare current outputs, then advance the model
  // across the coming rising edge.
  task automatic mon(input int d);
    logic e_ir;
    logic e_ov;
    if (!rstn[d]) begin
      m_st[d]   = 0;
      m_prod[d] = '0;
    end
    e_ir = rstn[d] && (m_st[d] == 0);
    e_ov = (m_st[d] == 2);
    nvec++;
    if (ir[d] !== e_ir || ov[d] !== e_ov
        || pr[d] !== m_prod[d]) begin
      nerr++;
      $display("FAIL dut%0d t=%0t rdy %b req %b vld %b req %b prod %h req %h",
               d, $time, ir[d], e_ir, ov[d], e_ov,
               pr[d], m_prod[d]);
    end
    if (rstn[d]) begin
      if (fl[d]) begin
        m_st[d] = 0;
      end else begin
        case (m_st[d])
          0: if (iv[d]) begin
            m_st[d]   = 1;
            m_left[d] = nn[d];
            m_exp[d]  = ref_prod(mc[d], mp[d], sg[d]);
          end
          1: begin
            m_left[d]--;
            if (m_left[d] == 0) begin
              m_st[d]   = 2;
              m_prod[d] = m_exp[d];
            end
          end
          default: if (ordy[d]) begin
            m_st[d] = 0;
            m_done[d]++;
          end
        endcase
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) mon(d);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op0(
    input logic [63:0]  a,
    input logic [63:0]  b,
    input logic         s,
    input logic [127:0] lit,
    input int           hold
  );
    int n;
    chk("pre_ready", 128'(ir[0]), 128'd1);
    iv[0] = 1'b1;
    mc[0] = a;
    mp[0] = b;
    sg[0] = s;
    tick();
    n = 0;
    // Busy-time requests must be ignored.
    while (!ov[0] && n < 200) begin
      mc[0] = rnd64();
      mp[0] = rnd64();
      tick();
      n++;
    end
    chk("latency", 128'(n), 128'd64);
    chk("prod", pr[0], lit);
    repeat (hold) tick();
    if (hold > 0) begin
      chk("hold_valid", 128'(ov[0]), 128'd1);
      chk("hold_ready", 128'(ir[0]), 128'd0);
      chk("hold_prod", pr[0], lit);
    end
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;
    iv[0]   = 1'b0;
    chk("post_valid", 128'(ov[0]), 128'd0);
    chk("post_ready", 128'(ir[0]), 128'd1);
    chk("post_prod", pr[0], lit);
  endtask

  task automatic abort0(input logic use_rst);
    int bad;
    iv[0] = 1'b1;
    mc[0] = 64'd9;
    mp[0] = 64'd9;
    sg[0] = 1'b0;
    tick();
    iv[0] = 1'b0;
    repeat (29) tick();
    if (use_rst) rstn[0] = 1'b0;
    else fl[0] = 1'b1;
    tick();
    rstn[0] = 1'b1;
    fl[0]   = 1'b0;
    bad = 0;
    repeat (80) begin
      if (ov[0]) bad++;
      tick();
    end
    chk("abort_no_valid", 128'(bad), 128'd0);
    op0(64'd2, 64'd2, 1'b0, 128'd4, 0);
  endtask

  initial begin
    int tgt [3];
    int cyc;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0;  sg[d] = 1'b0;
      fl[d] = 1'b0;  ordy[d] = 1'b0;
      mc[d] = '0;    mp[d] = '0;
      rstn[d] = 1'b1;
    end
    #1;
    for (int d = 0; d < 3; d++) rstn[d] = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 128'(ir[0]), 128'd0);
    chk("rst_valid", 128'(ov[0]), 128'd0);
    chk("rst_prod", pr[0], 128'd0);
    for (int d = 0; d < 3; d++) rstn[d] = 1'b1;
    #1;
    chk("rst_release_ready", 128'(ir[0]), 128'd1);
    tick();

    op0(64'd3, 64'd5, 1'b0, 128'd15, 0);
    op0(64'hFFFF_FFFF_FFFF_FFFF,
        64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
        128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001,
        0);
    op0(64'hFFFF_FFFF_FFFF_FFFF,
        64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 128'd1, 0);
    op0(64'hFFFF_FFFF_FFFF_FFF9, 64'd6, 1'b1,
        128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFD6,
        0);
    op0(64'h8000_0000_0000_0000,
        64'h8000_0000_0000_0000, 1'b1,
        128'h4000_0000_0000_0000_0000_0000_0000_0000,
        20);
    op0(64'd0, 64'h1_2345_6789, 1'b1, 128'd0, 0);
    op0(64'h8000_0000_0000_0000, 64'd1, 1'b1,
        128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000,
        0);
    abort0(1'b0);
    abort0(1'b1);

    tgt[0] = m_done[0] + 80;
    tgt[1] = m_done[1] + 1500;
    tgt[2] = m_done[2] + 1500;
    cyc = 0;
    while ((m_done[0] < tgt[0] || m_done[1] < tgt[1]
            || m_done[2] < tgt[2]) && cyc < 60000) begin
      for (int d = 0; d < 3; d++) begin
        iv[d]   = (m_done[d] < tgt[d])
                && ($urandom_range(3) != 0);
        mc[d]   = rnd64();
        mp[d]   = rnd64();
        sg[d]   = 1'($urandom_range(1));
        ordy[d] = ($urandom_range(3) != 0);
        fl[d]   = ($urandom_range(299) == 0);
        rstn[d] = ($urandom_range(999) != 0);
      end
      tick();
      cyc++;
    end
    chk("random_timeout", 128'(cyc < 60000), 128'd1);
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0;  fl[d] = 1'b0;
      ordy[d] = 1'b1; rstn[d] = 1'b1;
    end
    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
